// File: rtl/regfile_writeback_if.sv
// Bundle between the execute/memory producers, decode's hazard query and the
// register file write port, all wrapped around the writeback queue.
interface regfile_writeback_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            wb_hold;
    logic [4:0]      Sr1;
    logic [4:0]      Sr2;
    logic            rs1_pending;
    logic            rs2_pending;
    logic            RegWrite;
    logic [XLEN-1:0] WD3;
    logic [4:0]      DestR;
    logic [CW-1:0]   occupancy;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, wb_hold, Sr1, Sr2,
        input  a_ready, b_ready, rs1_pending, rs2_pending, RegWrite, WD3, DestR, occupancy
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, wb_hold, Sr1, Sr2,
        output a_ready, b_ready, rs1_pending, rs2_pending, RegWrite, WD3, DestR, occupancy
    );
endinterface

// File: rtl/regfile_writeback.sv
// In-order writeback FIFO that owns the register file write port and keeps a
// per-register count of queued writes for decode's RAW hazard stall.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst_n,
    regfile_writeback_if.slave wb
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [4:0]      rd_mem_q   [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   cnt_q [32];
    logic [CW-1:0]   cnt_d [32];

    logic            pop;
    logic            space;
    logic            a_fire;
    logic            b_fire;
    logic            enq;
    logic [4:0]      enq_rd;
    logic [XLEN-1:0] enq_data;
    logic [4:0]      head_rd;

    // Retiring frees a slot on the same edge, so a full queue still accepts
    // while draining; the load path wins when both producers are valid.
    always_comb begin
        pop      = (occ_q != '0) && !wb.wb_hold;
        space    = (occ_q < CW'(DEPTH)) || pop;
        b_fire   = wb.b_valid && space;
        a_fire   = wb.a_valid && space && !wb.b_valid;
        enq_rd   = b_fire ? wb.b_rd : wb.a_rd;
        enq_data = b_fire ? wb.b_data : wb.a_data;
        enq      = (a_fire || b_fire) && (enq_rd != 5'd0);
        head_rd  = rd_mem_q[rd_ptr_q];

        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;

        occ_d = occ_q;
        case ({enq, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if ((enq && enq_rd == 5'(r)) && !(pop && head_rd == 5'(r)))
                cnt_d[r] = cnt_q[r] + CW'(1);
            else if ((pop && head_rd == 5'(r)) && !(enq && enq_rd == 5'(r)))
                cnt_d[r] = cnt_q[r] - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            data_mem_q[wr_ptr_q] <= enq_data;
            rd_mem_q[wr_ptr_q]   <= enq_rd;
        end
    end

    assign wb.a_ready     = space && !wb.b_valid;
    assign wb.b_ready     = space;
    assign wb.RegWrite    = pop;
    assign wb.WD3         = data_mem_q[rd_ptr_q];
    assign wb.DestR       = head_rd;
    assign wb.occupancy   = occ_q;
    assign wb.rs1_pending = (wb.Sr1 != 5'd0) && (cnt_q[wb.Sr1] != '0);
    assign wb.rs2_pending = (wb.Sr2 != 5'd0) && (cnt_q[wb.Sr2] != '0);
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, hand-written
// hold/full/reset sequences and random traffic against a queue-based model.
module tb_regfile_writeback;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdata;
        logic [4:0]  sr1;
        logic        expAReady;
        logic        expBReady;
        logic        expRegWrite;
        logic [4:0]  expDest;
        logic [31:0] expWd3;
        logic [2:0]  expOcc;
        logic        expPend1;
    } vec_t;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    entry_t mq[$];
    logic   expAReady, expBReady, expPop;
    vec_t   vec [13];

    regfile_writeback_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) bus ();

    regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pendCount(input logic [4:0] r);
        int n = 0;
        foreach (mq[i]) if (mq[i].rd == r) n++;
        return n;
    endfunction

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic bv, input logic [4:0] brd, input logic [31:0] bdata,
                                 input logic hold, input logic [4:0] s1, input logic [4:0] s2);
        bus.a_valid = av;
        bus.a_rd    = ard;
        bus.a_data  = adata;
        bus.b_valid = bv;
        bus.b_rd    = brd;
        bus.b_data  = bdata;
        bus.wb_hold = hold;
        bus.Sr1     = s1;
        bus.Sr2     = s2;
        #1;
    endtask

    // Expected behaviour from the queue model: head retires unless held,
    // a slot is free if not full or if the head leaves this cycle.
    task automatic checkOutput();
        expPop    = (mq.size() != 0) && !bus.wb_hold;
        expBReady = (mq.size() < DEPTH) || expPop;
        expAReady = expBReady && !bus.b_valid;
        chk("b_ready", 32'(bus.b_ready), 32'(expBReady));
        chk("a_ready", 32'(bus.a_ready), 32'(expAReady));
        chk("RegWrite", 32'(bus.RegWrite), 32'(expPop));
        chk("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        if (expPop) begin
            chk("DestR", 32'(bus.DestR), 32'(mq[0].rd));
            chk("WD3", bus.WD3, mq[0].data);
        end
        chk("rs1_pending", 32'(bus.rs1_pending), 32'((bus.Sr1 != 0) && (pendCount(bus.Sr1) != 0)));
        chk("rs2_pending", 32'(bus.rs2_pending), 32'((bus.Sr2 != 0) && (pendCount(bus.Sr2) != 0)));
    endtask

    task automatic advance();
        entry_t e;
        logic aAcc, bAcc;
        aAcc = bus.a_valid && expAReady;
        bAcc = bus.b_valid && expBReady;
        @(posedge clk);
        if (expPop) void'(mq.pop_front());
        if (bAcc && bus.b_rd != 0) begin
            e.rd = bus.b_rd; e.data = bus.b_data; mq.push_back(e);
        end else if (aAcc && bus.a_rd != 0) begin
            e.rd = bus.a_rd; e.data = bus.a_data; mq.push_back(e);
        end
        #1;
    endtask

    task automatic idleStep(input logic hold, input logic [4:0] s1);
        applyStimulus(0, 0, 0, 0, 0, 0, hold, s1, s1);
        checkOutput();
        advance();
    endtask

    initial begin
        int retires;
        logic av, bv;
        logic [4:0] ard, brd;
        logic [31:0] adata, bdata;

        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5);
        #10;
        chk("reset RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("reset occupancy", 32'(bus.occupancy), 32'd0);
        chk("reset rs1_pending", 32'(bus.rs1_pending), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write, load priority, duplicate x7 writes, x0 drop.
        vec[0]  = '{1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 5'd5, 1, 1, 0, 5'd0, 32'h0,    3'd0, 0};
        vec[1]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd5, 1, 1, 1, 5'd5, 32'h1234, 3'd1, 1};
        vec[2]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd5, 1, 1, 0, 5'd0, 32'h0,    3'd0, 0};
        vec[3]  = '{1, 5'd3, 32'hA,    1, 5'd4, 32'hB, 5'd3, 0, 1, 0, 5'd0, 32'h0,    3'd0, 0};
        vec[4]  = '{1, 5'd3, 32'hA,    0, 5'd0, 32'h0, 5'd4, 1, 1, 1, 5'd4, 32'hB,    3'd1, 1};
        vec[5]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd3, 1, 1, 1, 5'd3, 32'hA,    3'd1, 1};
        vec[6]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd3, 1, 1, 0, 5'd0, 32'h0,    3'd0, 0};
        vec[7]  = '{1, 5'd7, 32'h70,   0, 5'd0, 32'h0, 5'd7, 1, 1, 0, 5'd0, 32'h0,    3'd0, 0};
        vec[8]  = '{1, 5'd7, 32'h71,   0, 5'd0, 32'h0, 5'd7, 1, 1, 1, 5'd7, 32'h70,   3'd1, 1};
        vec[9]  = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd7, 1, 1, 1, 5'd7, 32'h71,   3'd1, 1};
        vec[10] = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd7, 1, 1, 0, 5'd0, 32'h0,    3'd0, 0};
        vec[11] = '{1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0, 5'd0, 1, 1, 0, 5'd0, 32'h0,    3'd0, 0};
        vec[12] = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd0, 1, 1, 0, 5'd0, 32'h0,    3'd0, 0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vec[i].av, vec[i].ard, vec[i].adata, vec[i].bv, vec[i].brd,
                          vec[i].bdata, 0, vec[i].sr1, vec[i].sr1);
            chk($sformatf("vec%0d a_ready", i), 32'(bus.a_ready), 32'(vec[i].expAReady));
            chk($sformatf("vec%0d b_ready", i), 32'(bus.b_ready), 32'(vec[i].expBReady));
            chk($sformatf("vec%0d RegWrite", i), 32'(bus.RegWrite), 32'(vec[i].expRegWrite));
            chk($sformatf("vec%0d occupancy", i), 32'(bus.occupancy), 32'(vec[i].expOcc));
            chk($sformatf("vec%0d rs1_pending", i), 32'(bus.rs1_pending), 32'(vec[i].expPend1));
            if (vec[i].expRegWrite) begin
                chk($sformatf("vec%0d DestR", i), 32'(bus.DestR), 32'(vec[i].expDest));
                chk($sformatf("vec%0d WD3", i), bus.WD3, vec[i].expWd3);
            end
            checkOutput();
            advance();
        end

        // Hold fills the queue; the fifth request waits for the drain.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 1, 5'(i + 1), 5'd1);
            if (i == 4) begin
                chk("hold full occupancy", 32'(bus.occupancy), 32'd4);
                chk("hold full a_ready", 32'(bus.a_ready), 32'd0);
            end
            checkOutput();
            advance();
        end
        retires = 0;
        applyStimulus(1, 5'd5, 32'h104, 0, 0, 0, 0, 5'd5, 5'd1);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd1);
            checkOutput();
            if (bus.RegWrite) retires++;
            advance();
        end
        chk("hold release retires", 32'(retires), 32'd5);

        // Full queue with retirement enabled keeps accepting every cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 5'(8 + i), 32'h200 + 32'(i), 0, 0, 0, 1, 5'd8, 5'd9);
            checkOutput();
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 5'(12 + i), 32'h300 + 32'(i), 0, 0, 0, 0, 5'd12, 5'd8);
            chk("streaming a_ready", 32'(bus.a_ready), 32'd1);
            chk("streaming occupancy", 32'(bus.occupancy), 32'd4);
            checkOutput();
            advance();
        end
        for (int i = 0; i < 5; i++) idleStep(0, 5'd15);

        // Reset in the middle of a held queue discards everything.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'(20 + i), 32'h400 + 32'(i), 0, 0, 0, 1, 5'd20, 5'd21);
            checkOutput();
            advance();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
        chk("pre-reset occupancy", 32'(bus.occupancy), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid-reset RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("mid-reset occupancy", 32'(bus.occupancy), 32'd0);
        chk("mid-reset rs1_pending", 32'(bus.rs1_pending), 32'd0);
        chk("mid-reset rs2_pending", 32'(bus.rs2_pending), 32'd0);
        mq.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) idleStep(0, 5'd20);

        // Random traffic; producers hold their request until it is accepted.
        av = 0; bv = 0; ard = 0; brd = 0; adata = 0; bdata = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!av && ($urandom_range(0, 2) != 0)) begin
                av = 1; ard = 5'($urandom_range(0, 31)); adata = $urandom;
            end
            if (!bv && ($urandom_range(0, 2) == 0)) begin
                bv = 1; brd = 5'($urandom_range(0, 31)); bdata = $urandom;
            end
            applyStimulus(av, ard, adata, bv, brd, bdata, ($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 31)), (mq.size() != 0) ? mq[0].rd : 5'd0);
            checkOutput();
            if (av && expAReady) av = 0;
            if (bv && expBReady) bv = 0;
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
